// File: rtl/ice_i2c_pkg.sv
// Shared I2C definitions: state encoding, ACK/NACK bus levels and the R/nW bit
// position in the address byte. Used by both the target and the initiator.
package ice_i2c_pkg;

    typedef enum logic [2:0] {
        SM_IDLE      = 3'd0,
        SM_ADDR      = 3'd1,
        SM_ADDR_ACK  = 3'd2,
        SM_WDATA     = 3'd3,
        SM_WDATA_ACK = 3'd4,
        SM_RDATA     = 3'd5,
        SM_RDATA_ACK = 3'd6,
        SM_WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int RNW_BIT = 0;

endpackage

// File: rtl/ice_i2c_line_cond.sv
// SCL/SDA conditioning: synchroniser chain, N-sample glitch filter, and
// one-cycle strobes for SCL edges and START/STOP bus conditions.
module ice_i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic [FILT_LEN-2:0]    r_scl_hist;
    logic [FILT_LEN-2:0]    r_sda_hist;
    logic                   r_scl_f;
    logic                   r_sda_f;

    logic [FILT_LEN-1:0]    w_scl_samp;
    logic [FILT_LEN-1:0]    w_sda_samp;
    logic                   w_scl_new;
    logic                   w_sda_new;
    logic                   w_sda_rise;
    logic                   w_sda_fall;

    assign w_scl_samp = {r_scl_hist, r_scl_sync[SYNC_STAGES-1]};
    assign w_sda_samp = {r_sda_hist, r_sda_sync[SYNC_STAGES-1]};

    // A level is only accepted once every sample in the window agrees.
    assign w_scl_new = (&w_scl_samp) ? 1'b1 : ((|w_scl_samp) ? r_scl_f : 1'b0);
    assign w_sda_new = (&w_sda_samp) ? 1'b1 : ((|w_sda_samp) ? r_sda_f : 1'b0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_hist <= w_scl_samp[FILT_LEN-2:0];
            r_sda_hist <= w_sda_samp[FILT_LEN-2:0];
            r_scl_f    <= w_scl_new;
            r_sda_f    <= w_sda_new;
        end
    end

    assign w_sda_rise = w_sda_new & ~r_sda_f;
    assign w_sda_fall = ~w_sda_new & r_sda_f;

    assign o_sda      = r_sda_f;
    assign o_scl_rise = w_scl_new & ~r_scl_f;
    assign o_scl_fall = ~w_scl_new & r_scl_f;
    // SCL must be high both before and after the SDA edge to count as a bus condition.
    assign o_start    = w_sda_fall & r_scl_f & w_scl_new;
    assign o_stop     = w_sda_rise & r_scl_f & w_scl_new;

endmodule

// File: rtl/ice_i2c_target.sv
// I2C target front end: fixed-address match, ACK generation, byte delivery for
// writes and app-supplied byte shift-out for reads. SDA is open-drain only.
module ice_i2c_target
    import ice_i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_low,
    output logic [7:0] o_wdata,
    output logic       o_wvalid,
    output logic       o_rreq,
    input  logic [7:0] i_rdata,
    output logic       o_busy
);

    logic w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;

    ice_i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_line_cond (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (w_sda_f),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_t r_state, w_state_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_tx, w_tx_nxt;
    logic       r_rnw, w_rnw_nxt;
    // In ACK states: first fall already seen. In RDATA: bit7 still to be driven.
    logic       r_phase, w_phase_nxt;
    logic [1:0] r_ld, w_ld_nxt;
    logic       r_sda_low, w_sda_low_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic       r_wvalid, w_wvalid_nxt;
    logic       r_rreq, w_rreq_nxt;
    logic       r_busy, w_busy_nxt;

    logic [7:0] w_byte;
    logic [2:0] w_tx_idx;

    assign w_byte   = {r_shift[6:0], w_sda_f};
    assign w_tx_idx = 3'd6 - r_bitcnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_rnw_nxt     = r_rnw;
        w_phase_nxt   = r_phase;
        w_sda_low_nxt = r_sda_low;
        w_wdata_nxt   = r_wdata;
        w_wvalid_nxt  = 1'b0;
        w_rreq_nxt    = 1'b0;
        w_busy_nxt    = r_busy;

        if (w_stop) begin
            w_state_nxt   = SM_IDLE;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = SM_ADDR;
            w_sda_low_nxt = 1'b0;
            w_bitcnt_nxt  = 3'd0;
            w_phase_nxt   = 1'b0;
        end else begin
            case (r_state)
                SM_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            // General call (address 0) is deliberately never answered.
                            if (w_byte[7:1] == ADDR && w_byte[7:1] != 7'd0) begin
                                w_state_nxt = SM_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rnw_nxt   = w_byte[RNW_BIT];
                                w_phase_nxt = 1'b0;
                                w_rreq_nxt  = w_byte[RNW_BIT];
                            end else begin
                                w_state_nxt = SM_WAIT_STOP;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                SM_ADDR_ACK, SM_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_low_nxt = 1'b1;
                            w_phase_nxt   = 1'b1;
                        end else begin
                            w_phase_nxt  = 1'b0;
                            w_bitcnt_nxt = 3'd0;
                            if (r_state == SM_ADDR_ACK && r_rnw) begin
                                w_state_nxt   = SM_RDATA;
                                w_sda_low_nxt = ~r_tx[7];
                            end else begin
                                w_state_nxt   = SM_WDATA;
                                w_sda_low_nxt = 1'b0;
                            end
                        end
                    end
                end
                SM_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_wdata_nxt  = w_byte;
                            w_wvalid_nxt = 1'b1;
                            w_state_nxt  = SM_WDATA_ACK;
                            w_phase_nxt  = 1'b0;
                        end
                    end
                end
                SM_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_phase) begin
                            w_sda_low_nxt = ~r_tx[7];
                            w_phase_nxt   = 1'b0;
                        end else if (r_bitcnt == 3'd7) begin
                            w_sda_low_nxt = 1'b0;
                            w_state_nxt   = SM_RDATA_ACK;
                        end else begin
                            w_sda_low_nxt = ~r_tx[w_tx_idx];
                            w_bitcnt_nxt  = r_bitcnt + 3'd1;
                        end
                    end
                end
                SM_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_f == I2C_ACK) begin
                            w_rreq_nxt   = 1'b1;
                            w_state_nxt  = SM_RDATA;
                            w_phase_nxt  = 1'b1;
                            w_bitcnt_nxt = 3'd0;
                        end else begin
                            w_state_nxt = SM_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The app has two cycles after o_rreq to present i_rdata.
    assign w_ld_nxt = {r_ld[0], w_rreq_nxt};
    assign w_tx_nxt = r_ld[1] ? i_rdata : r_tx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= SM_IDLE;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 8'd0;
            r_rnw     <= 1'b0;
            r_phase   <= 1'b0;
            r_ld      <= 2'd0;
            r_sda_low <= 1'b0;
            r_wdata   <= 8'd0;
            r_wvalid  <= 1'b0;
            r_rreq    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_rnw     <= w_rnw_nxt;
            r_phase   <= w_phase_nxt;
            r_ld      <= w_ld_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_rreq    <= w_rreq_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign o_sda_low = r_sda_low;
    assign o_wdata   = r_wdata;
    assign o_wvalid  = r_wvalid;
    assign o_rreq    = r_rreq;
    assign o_busy    = r_busy;

endmodule
